irq_ctl: RTL and testbench
==========================

# irq_ctl

Machine-level interrupt controller feeding the RISC-V pipeline's trap path. It detects external interrupt edges and, optionally, a machine-timer compare. It holds a prioritised trap request to the core until the core acknowledges trap entry, then blocks further requests until the core retires `mret`. It is memory-mapped on the data-memory bus and shares the core's clock and clock-enable.

## Interface
- `NUM_EXT`, 4: number of external interrupt lines (1..8).
- `PRESCALE`, 1: enabled clock cycles per mtime increment (≥1).
- `i_clk`  in  1  core clock.
- `i_rst`  in  1  reset; asynchronous, active-low.
- `i_clk_en`  in  1  core clock-enable; gates all architectural state updates.
- `i_ext_irq`  in  NUM_EXT  asynchronous external interrupt lines.
- `i_mie`  in  1  mstatus.MIE from the CSR file; global interrupt enable.
- `i_irq_ack`  in  1  core has taken the trap; one-cycle pulse.
- `i_mret`  in  1  core executed `mret`; one-cycle pulse.
- `i_sel`  in  1  bus select.
- `i_we`  in  1  bus write.
- `i_addr`  in  5  byte address.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  registered read data.
- `o_irq_req`  out  1  trap request to the core.
- `o_irq_cause`  out  5  mcause code; valid while `o_irq_req` is high.

## Operation
- Register map:
  - 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 IRQ_EN: bit 0 timer, bits 1..NUM_EXT external.
  - 0x14 IRQ_PEND: same layout; external bits are write-1-to-clear, the timer bit is read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- External lines:
  - Each line passes through a 2-flop synchroniser and a rising-edge detector that run every `i_clk`, independent of `i_clk_en`.
  - A detected edge sets its pending bit.
  - If an edge set and a W1C clear hit the same bit in the same cycle, the set wins.
- Timer pending: level `mtime >= mtimecmp` (unsigned 64-bit compare). It is cleared only by software raising MTIMECMP.
- mtime:
  - 64-bit counter; increments by 1 every PRESCALE enabled cycles; carries from LO into HI; wraps from 2^64−1 to 0.
  - A bus write to either half takes precedence over the increment in that cycle.
- Priority, highest first: timer (cause 7), then ext0 (cause 16) up to ext[NUM_EXT−1] (cause 16+NUM_EXT−1).
- FSM:
  - IDLE → REQ when `i_mie` is high and (IRQ_PEND & IRQ_EN) ≠ 0. On entry, the winning cause is latched.
  - REQ → SVC on `i_irq_ack`. The latched external pending bit is cleared in the same cycle.
  - SVC → IDLE on `i_mret`.
  - `i_irq_ack` outside REQ and `i_mret` outside SVC are ignored.
- Handshake:
  - In REQ, `o_irq_req` and `o_irq_cause` are held stable until ack, even if `i_mie`, IRQ_EN or pending change.
  - `o_irq_req` is high only in REQ.
- All FSM, register and counter updates occur only when `i_clk_en` is high.

## Timing
- Reset values: `o_irq_req` 0, `o_irq_cause` 0, `o_rdata` 0, FSM IDLE; all registers 0, synchronisers 0.
- With `i_clk_en` held high, the external pin rising at edge n gives:
  - pending set at n+3;
  - `o_irq_req` high at n+4.
- Read latency: `o_rdata` updates one enabled cycle after `i_sel` with `i_we` low. It holds its value otherwise.
- Write effect: visible in register state on the next enabled edge.
- Ack and a new edge in the same cycle: the new pending bit is set, but the request is not raised until the FSM returns to IDLE.
- `i_mret` and a pending interrupt in the same cycle: the FSM goes to IDLE that cycle and re-requests on the following enabled cycle.
- Reset asserted mid-request: `o_irq_req` drops immediately (asynchronously), and all state clears.

## Configuration
- Macro: `IRQ_CTL_TIMER_EN`.
- Defined: mtime/mtimecmp, the prescaler and timer pending/cause 7 are implemented.
- Undefined:
  - The timer logic is absent.
  - Addresses 0x00–0x0C read 0 and ignore writes.
  - IRQ_EN and IRQ_PEND bit 0 read 0.
  - Only external causes are produced.

## Structure
- Shared package `irq_ctl_pkg`: register address constants, cause codes (7, 16+k), FSM state encodings (IDLE, REQ, SVC).
- Sub-module `irq_sync_edge`: 2-flop synchroniser plus rising-edge pulse. It is instantiated once per external line via generate.

## Test plan
- Reset, IRQ_EN=0x02, `i_mie`=1, pulse `i_ext_irq[0]` → `o_irq_req`=1 with cause 16 four cycles later; ack → IRQ_PEND bit 1 reads 0; req stays low until `i_mret`.
- Set MTIMECMP=10 and IRQ_EN=0x03, pulse ext0 and let the timer compare hit at the same time → cause 7 first; after ack+mret, cause 16.
- In REQ, drop `i_mie` and clear IRQ_EN → req and cause remain stable until `i_irq_ack`.
- Write MTIME_LO=0xFFFF_FFFF, HI=0 → after one increment, reads give LO=0 and HI=1; hold `i_clk_en`=0 for 5 cycles → mtime is unchanged.
- Write W1C 0x02 in the same cycle as an ext0 edge → the bit stays set.
- Assert reset while in SVC → req=0 and FSM IDLE; IRQ_EN reads 0 after release.

Source files
------------

// File: rtl/irq_ctl_pkg.sv
// rtl/irq_ctl_pkg.sv - shared constants, cause codes and FSM states for irq_ctl
package irq_ctl_pkg;

    localparam logic [4:0] ADDR_MTIME_LO    = 5'h00;
    localparam logic [4:0] ADDR_MTIME_HI    = 5'h04;
    localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_EN      = 5'h10;
    localparam logic [4:0] ADDR_IRQ_PEND    = 5'h14;

    localparam logic [4:0] CAUSE_TIMER    = 5'd7;
    localparam logic [4:0] CAUSE_EXT_BASE = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_e;

    function automatic logic [4:0] ext_cause(input int k);
        return CAUSE_EXT_BASE + 5'(k);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - 2-flop synchroniser with registered rising-edge pulse
module irq_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // The pulse is held across disabled cycles so an edge is never lost
    // before the first enabled cycle can latch it into the pending bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= (r_sync & ~r_prev) | (r_pulse & ~i_clk_en);
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - machine interrupt controller; optional timer under IRQ_CTL_TIMER_EN
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int NUM_EXT  = 4,
    parameter int PRESCALE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clk_en,
    input  logic [NUM_EXT-1:0] i_ext_irq,
    input  logic               i_mie,
    input  logic               i_irq_ack,
    input  logic               i_mret,
    input  logic               i_sel,
    input  logic               i_we,
    input  logic [4:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_irq_req,
    output logic [4:0]         o_irq_cause
);

    logic               w_wr;
    logic               w_rd;
    logic [NUM_EXT-1:0] w_edge;
    logic [NUM_EXT-1:0] w_w1c;
    logic [NUM_EXT-1:0] w_ack_clr;
    logic [NUM_EXT-1:0] w_pend_ext_nxt;
    logic [NUM_EXT-1:0] r_pend_ext;
    logic [NUM_EXT-1:0] r_en_ext;
    logic               w_tmr_pend;
    logic               w_tmr_en;
    logic [NUM_EXT:0]   w_active;
    logic [4:0]         w_win_cause;
    irq_state_e         r_state;
    irq_state_e         w_state_nxt;
    logic [4:0]         r_cause;
    logic [4:0]         w_cause_nxt;
    logic [31:0]        w_rd_mux;
    logic [31:0]        r_rdata;
    logic               w_unused;

    assign w_wr     = i_clk_en & i_sel & i_we;
    assign w_rd     = i_clk_en & i_sel & ~i_we;
    assign w_unused = ^i_wdata;

    for (genvar k = 0; k < NUM_EXT; k++) begin : g_sync
        irq_sync_edge u_sync (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clk_en (i_clk_en),
            .i_async  (i_ext_irq[k]),
            .o_pulse  (w_edge[k])
        );
    end

`ifdef IRQ_CTL_TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic [PW-1:0] r_presc;
    logic          r_en_tmr;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(PRESCALE - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '0;
            r_presc    <= '0;
            r_en_tmr   <= 1'b0;
        end else if (i_clk_en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_wr && i_addr == ADDR_MTIME_LO)
                r_mtime[31:0] <= i_wdata;
            else if (w_wr && i_addr == ADDR_MTIME_HI)
                r_mtime[63:32] <= i_wdata;
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;
            if (w_wr && i_addr == ADDR_MTIMECMP_LO)
                r_mtimecmp[31:0] <= i_wdata;
            if (w_wr && i_addr == ADDR_MTIMECMP_HI)
                r_mtimecmp[63:32] <= i_wdata;
            if (w_wr && i_addr == ADDR_IRQ_EN)
                r_en_tmr <= i_wdata[0];
        end
    end

    assign w_tmr_pend = (r_mtime >= r_mtimecmp);
    assign w_tmr_en   = r_en_tmr;
`else
    assign w_tmr_pend = 1'b0;
    assign w_tmr_en   = 1'b0;
`endif

    assign w_w1c = (w_wr && i_addr == ADDR_IRQ_PEND) ? i_wdata[NUM_EXT:1] : '0;

    always_comb begin
        w_ack_clr = '0;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (r_state == ST_REQ && i_irq_ack && r_cause == ext_cause(k))
                w_ack_clr[k] = 1'b1;
        end
    end

    // A fresh edge wins over both software W1C and the ack-driven clear.
    assign w_pend_ext_nxt = (r_pend_ext & ~w_w1c & ~w_ack_clr) | w_edge;
    assign w_active       = {r_pend_ext, w_tmr_pend} & {r_en_ext, w_tmr_en};

    always_comb begin
        w_win_cause = '0;
        for (int k = NUM_EXT - 1; k >= 0; k--) begin
            if (w_active[k+1])
                w_win_cause = ext_cause(k);
        end
        if (w_active[0])
            w_win_cause = CAUSE_TIMER;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (i_mie && |w_active) begin
                    w_state_nxt = ST_REQ;
                    w_cause_nxt = w_win_cause;
                end
            end
            ST_REQ:  if (i_irq_ack) w_state_nxt = ST_SVC;
            ST_SVC:  if (i_mret)    w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (i_addr)
`ifdef IRQ_CTL_TIMER_EN
            ADDR_MTIME_LO:    w_rd_mux = r_mtime[31:0];
            ADDR_MTIME_HI:    w_rd_mux = r_mtime[63:32];
            ADDR_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
            ADDR_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
`endif
            ADDR_IRQ_EN:      w_rd_mux[NUM_EXT:0] = {r_en_ext, w_tmr_en};
            ADDR_IRQ_PEND:    w_rd_mux[NUM_EXT:0] = {r_pend_ext, w_tmr_pend};
            default:          w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_cause    <= '0;
            r_pend_ext <= '0;
            r_en_ext   <= '0;
            r_rdata    <= '0;
        end else if (i_clk_en) begin
            r_state    <= w_state_nxt;
            r_cause    <= w_cause_nxt;
            r_pend_ext <= w_pend_ext_nxt;
            if (w_wr && i_addr == ADDR_IRQ_EN)
                r_en_ext <= i_wdata[NUM_EXT:1];
            if (w_rd)
                r_rdata <= w_rd_mux;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_irq_req   = (r_state == ST_REQ);
    assign o_irq_cause = r_cause;

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - scoreboard bench for irq_ctl with randomized pending/enable traffic
module tb_irq_ctl;

    localparam int NUM_EXT = 4;
`ifdef IRQ_CTL_TIMER_EN
    localparam bit TMR_BUILD = 1'b1;
`else
    localparam bit TMR_BUILD = 1'b0;
`endif
    localparam logic [4:0] A_MT_LO  = 5'h00;
    localparam logic [4:0] A_MT_HI  = 5'h04;
    localparam logic [4:0] A_CMP_LO = 5'h08;
    localparam logic [4:0] A_CMP_HI = 5'h0C;
    localparam logic [4:0] A_EN     = 5'h10;
    localparam logic [4:0] A_PEND   = 5'h14;
    localparam logic [4:0] A_UNMAP  = 5'h18;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en = 1'b1;
    logic [NUM_EXT-1:0] ext = '0;
    logic               mie = 1'b0;
    logic               ack = 1'b0;
    logic               mret = 1'b0;
    logic               sel = 1'b0;
    logic               we = 1'b0;
    logic [4:0]         addr = '0;
    logic [31:0]        wdata = '0;
    logic [31:0]        rdata;
    logic               irq_req;
    logic [4:0]         irq_cause;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rd_q[$];
    logic [4:0]  exp_cause_q[$];
    logic        rd_flag = 1'b0;
    logic        prev_req = 1'b0;
    logic [4:0]  cur_cause = '0;

    logic [NUM_EXT-1:0] m_en;
    logic [NUM_EXT-1:0] m_pend;
    logic               m_tmr;

    always #5 clk = ~clk;

    irq_ctl #(.NUM_EXT(NUM_EXT), .PRESCALE(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_clk_en    (clk_en),
        .i_ext_irq   (ext),
        .i_mie       (mie),
        .i_irq_ack   (ack),
        .i_mret      (mret),
        .i_sel       (sel),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_irq_req   (irq_req),
        .o_irq_cause (irq_cause)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_flag <= sel && !we && clk_en && rst_n;

    always @(negedge clk) begin
        if (rd_flag) begin
            if (exp_rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got 0x%0h with nothing expected", rdata);
            end else begin
                check("rdata", rdata, exp_rd_q.pop_front());
            end
        end
        if (irq_req && !prev_req) begin
            if (exp_cause_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected: cause %0d raised with nothing expected", irq_cause);
            end else begin
                cur_cause = exp_cause_q.pop_front();
                check("cause", 32'(irq_cause), 32'(cur_cause));
            end
        end else if (irq_req && prev_req) begin
            check("cause_hold", 32'(irq_cause), 32'(cur_cause));
        end
        prev_req = irq_req;
    end

    function automatic logic [31:0] pend_word();
        return 32'({m_pend, m_tmr});
    endfunction

    function automatic logic [31:0] en_word(input logic [NUM_EXT-1:0] e);
        return 32'(e) << 1;
    endfunction

    function automatic int lowest_bit(input logic [NUM_EXT-1:0] v);
        for (int k = 0; k < NUM_EXT; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        sel = 1'b1; we = 1'b0; addr = a;
        tick(1);
        sel = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_EXT-1:0] lines);
        ext = ext | lines;
        tick(3);
        ext = ext & ~lines;
        tick(4);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!irq_req && n < 50) begin
            tick(1);
            n++;
        end
        if (!irq_req) begin
            checks++; errors++;
            $display("FAIL %s: no request within 50 cycles, expected one", name);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1; tick(1); mret = 1'b0;
    endtask

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_tmr = TMR_BUILD;
    endtask

    initial begin
        int n;
        logic [NUM_EXT-1:0] r_lines;
        int k;
        int guard;

        model_reset();
        tick(2);
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_cause", 32'(irq_cause), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick(1);
        bus_rd(A_EN, 32'd0);
        bus_rd(A_PEND, pend_word());
        bus_rd(A_UNMAP, 32'd0);

`ifdef IRQ_CTL_TIMER_EN
        // timer and ext0 become pending on the same edge: timer must win
        bus_wr(A_MT_LO, 32'd0);
        bus_wr(A_CMP_LO, 32'd10);
        bus_wr(A_EN, 32'h3);
        mie = 1'b1;
        exp_cause_q.push_back(5'd7);
        exp_cause_q.push_back(5'd16);
        tick(4);
        ext[0] = 1'b1; tick(3); ext[0] = 1'b0;
        wait_req("tmr_req");
        do_ack();
        bus_wr(A_CMP_HI, 32'hFFFF_FFFF);
        m_tmr = 1'b0;
        do_mret();
        wait_req("tmr_ext_req");
        do_ack();
        do_mret();
        mie = 1'b0;
        bus_wr(A_EN, 32'd0);
        bus_rd(A_PEND, pend_word());
        bus_wr(A_MT_HI, 32'd0);
        bus_wr(A_MT_LO, 32'hFFFF_FFFF);
        tick(1);
        bus_rd(A_MT_LO, 32'd0);
        bus_rd(A_MT_HI, 32'd1);
        bus_rd(A_MT_LO, 32'd2);
        clk_en = 1'b0;
        tick(5);
        clk_en = 1'b1;
        bus_rd(A_MT_LO, 32'd3);
`else
        bus_wr(A_MT_LO, 32'hFFFF_FFFF);
        bus_wr(A_CMP_LO, 32'h1234);
        bus_rd(A_MT_LO, 32'd0);
        bus_rd(A_CMP_LO, 32'd0);
        bus_wr(A_EN, 32'h1);
        bus_rd(A_EN, 32'd0);
`endif

        // ext0 latency, ack clears pending, no re-request before mret
        bus_wr(A_EN, 32'h2); m_en = 4'b0001;
        mie = 1'b1;
        exp_cause_q.push_back(5'd16);
        ext[0] = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!irq_req && n < 20);
        check("req_latency", n, 5);
        ext[0] = 1'b0;
        do_ack();
        bus_rd(A_PEND, pend_word());
        pulse(4'b0001); m_pend[0] = 1'b1;
        check("req_low_in_svc", 32'(irq_req), 32'd0);
        bus_rd(A_PEND, pend_word());
        exp_cause_q.push_back(5'd16);
        do_mret();
        tick(1);
        check("req_after_mret", 32'(irq_req), 32'd1);
        do_ack(); m_pend[0] = 1'b0;
        do_mret();

        // request stays stable while mie and enable are withdrawn
        exp_cause_q.push_back(5'd16);
        pulse(4'b0001);
        wait_req("hold_req");
        mie = 1'b0;
        bus_wr(A_EN, 32'd0); m_en = '0;
        tick(3);
        check("req_hold", 32'(irq_req), 32'd1);
        do_ack();
        do_mret();
        tick(2);
        check("req_idle_after_hold", 32'(irq_req), 32'd0);

        // W1C coinciding with a new edge leaves the bit set
        pulse(4'b0001); m_pend[0] = 1'b1;
        ext[0] = 1'b1;
        tick(3);
        bus_wr(A_PEND, 32'h2);
        ext[0] = 1'b0;
        tick(2);
        bus_rd(A_PEND, pend_word());
        bus_wr(A_PEND, 32'h2); m_pend[0] = 1'b0;
        bus_rd(A_PEND, pend_word());

        for (int it = 0; it < 20; it++) begin
            mie = 1'b0;
            m_en = NUM_EXT'($urandom_range(0, (1 << NUM_EXT) - 1));
            bus_wr(A_EN, en_word(m_en));
            bus_rd(A_EN, en_word(m_en));
            r_lines = NUM_EXT'($urandom_range(0, (1 << NUM_EXT) - 1));
            if (r_lines != 0) begin
                pulse(r_lines);
                m_pend = m_pend | r_lines;
            end
            bus_rd(A_PEND, pend_word());
            mie = 1'b1;
            guard = 0;
            while ((m_pend & m_en) != 0 && guard < NUM_EXT) begin
                k = lowest_bit(m_pend & m_en);
                exp_cause_q.push_back(5'(16 + k));
                wait_req("rand_req");
                do_ack();
                m_pend[k] = 1'b0;
                tick($urandom_range(0, 2));
                do_mret();
                guard++;
            end
            tick(2);
            check("rand_req_idle", 32'(irq_req), 32'd0);
            mie = 1'b0;
            r_lines = NUM_EXT'($urandom_range(0, (1 << NUM_EXT) - 1));
            bus_wr(A_PEND, en_word(r_lines));
            m_pend = m_pend & ~r_lines;
            bus_rd(A_PEND, pend_word());
        end

        // reset during REQ drops the request asynchronously
        bus_wr(A_EN, 32'h2); m_en = 4'b0001;
        mie = 1'b1;
        exp_cause_q.push_back(5'd16);
        pulse(4'b0001);
        wait_req("rst_req_setup");
        rst_n = 1'b0;
        #1;
        check("rst_async_req", 32'(irq_req), 32'd0);
        check("rst_async_cause", 32'(irq_cause), 32'd0);
        tick(1);
        rst_n = 1'b1;
        model_reset();
        bus_rd(A_EN, 32'd0);
        bus_rd(A_PEND, pend_word());

        // reset during SVC returns to IDLE
        bus_wr(A_EN, 32'h2); m_en = 4'b0001;
        exp_cause_q.push_back(5'd16);
        pulse(4'b0001);
        wait_req("svc_setup");
        do_ack();
        rst_n = 1'b0;
        tick(1);
        check("rst_svc_req", 32'(irq_req), 32'd0);
        rst_n = 1'b1;
        model_reset();
        bus_rd(A_EN, 32'd0);
        bus_wr(A_EN, 32'h2); m_en = 4'b0001;
        exp_cause_q.push_back(5'd16);
        pulse(4'b0001);
        wait_req("post_rst_req");
        do_ack();
        do_mret();
        mie = 1'b0;

        tick(5);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("cause_queue_drained", exp_cause_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
